// File: rtl/sliding_window_sum.sv
// Moving-window sum over the last 2^LOG_W accepted samples.
// Doubling adder tree with per-stage delay lines that advance only on accepted samples.
// Ports:
//   clk, rst (async, active high), clear (sync flush)
//   in_valid/in_data  : sample input
//   out_valid/out_sum : one-cycle update pulse and full-width window sum
//   out_full          : W samples accepted since reset/clear
//   out_mean          : rounded window mean, only with SLIDING_WINDOW_SUM_MEAN_EN
module sliding_window_sum #(
  parameter int LOG_W = 3,
  parameter int DW    = 8,
  localparam int OW   = DW + LOG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [OW-1:0] out_sum,
`ifdef SLIDING_WINDOW_SUM_MEAN_EN
  output logic [DW-1:0] out_mean,
`endif
  output logic          out_full
);

  // Bit offset of tree level j in the packed tree bus.
  // Level j is DW+j bits wide, so every bit of the bus is used.
  function automatic int off(int j);
    return j * DW + (j * (j - 1)) / 2;
  endfunction

  localparam int TW = off(LOG_W + 1);

  logic [TW-1:0] tree;

  assign tree[DW-1:0] = in_data;

  for (genvar k = 0; k < LOG_W; k++) begin : g_stage
    localparam int IW = DW + k;
    localparam int D  = 1 << k;
    localparam int OI = off(k);
    localparam int OO = off(k + 1);

    logic [IW-1:0] din;
    logic [IW-1:0] dl_q [D];
    logic [IW-1:0] dl_d [D];
    logic [IW:0]   s;

    assign din = tree[OI +: IW];
    // Current level value plus the same level D accepts ago.
    assign s = {1'b0, din} + {1'b0, dl_q[D-1]};
    assign tree[OO +: IW+1] = s;

    always_comb begin
      dl_d = dl_q;
      if (clear) begin
        for (int i = 0; i < D; i++) dl_d[i] = '0;
      end else if (in_valid) begin
        dl_d[0] = din;
        for (int i = 1; i < D; i++) dl_d[i] = dl_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < D; i++) dl_q[i] <= '0;
      end else begin
        dl_q <= dl_d;
      end
    end
  end

  logic [OW-1:0]  sum_q, sum_d;
  logic           vld_q, vld_d;
  logic [LOG_W:0] cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    vld_d = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      sum_d = tree[off(LOG_W) +: OW];
      vld_d = 1'b1;
      // Counter saturates at W, which is exactly when the MSB sets.
      if (!cnt_q[LOG_W]) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_valid = vld_q;
  assign out_full  = cnt_q[LOG_W];

`ifdef SLIDING_WINDOW_SUM_MEAN_EN
  localparam logic [OW-1:0] HALF = OW'(1 << (LOG_W - 1));

  logic [DW-1:0] mean_q, mean_d;

  // sum + W/2 never exceeds OW bits, so no carry is lost.
  always_comb begin
    mean_d = DW'((sum_d + HALF) >> LOG_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mean_q <= '0;
    else     mean_q <= mean_d;
  end

  assign out_mean = mean_q;
`endif

endmodule

// File: tb/tb_sliding_window_sum.sv
// Scoreboard bench for sliding_window_sum against a queue-based window model.
// Directed test-plan sequences followed by randomized valid/clear/data traffic.
module tb_sliding_window_sum;
  localparam int LOG_W = 3;
  localparam int DW    = 8;
  localparam int OW    = DW + LOG_W;
  localparam int W     = 1 << LOG_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [OW-1:0] out_sum;
  logic          out_full;
`ifdef SLIDING_WINDOW_SUM_MEAN_EN
  logic [DW-1:0] out_mean;
`endif

  always #5 clk = ~clk;

  sliding_window_sum #(.LOG_W(LOG_W), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_sum  (out_sum),
`ifdef SLIDING_WINDOW_SUM_MEAN_EN
    .out_mean (out_mean),
`endif
    .out_full (out_full)
  );

  typedef struct {
    int sum;
    bit full;
    int mean;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   acc;
  int   hold_sum;
  bit   hold_full;
  int   hold_mean;
  int   errs;
  int   checks;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int win_sum();
    int s;
    s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  task automatic model_flush();
    hist.delete();
    acc       = 0;
    hold_sum  = 0;
    hold_full = 0;
    hold_mean = 0;
  endtask

  // Drive one cycle of inputs, update the model at the edge.
  task automatic step(bit v, int d, bit c);
    exp_t e;
    logic [DW-1:0] dv;
    dv       = DW'(d);
    in_valid = v;
    in_data  = dv;
    clear    = c;
    @(posedge clk);
    if (c) begin
      model_flush();
    end else if (v) begin
      hist.push_back(int'(dv));
      if (hist.size() > W) void'(hist.pop_front());
      acc++;
      e.sum  = win_sum();
      e.full = (acc >= W);
      e.mean = (e.sum + W / 2) / W;
      sb.push_back(e);
      hold_sum  = e.sum;
      hold_full = e.full;
      hold_mean = e.mean;
    end
    #1;
  endtask

  // Monitor: pop on every output pulse, otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", int'(out_sum), e.sum);
          chk("full", int'(out_full), int'(e.full));
`ifdef SLIDING_WINDOW_SUM_MEAN_EN
          chk("mean", int'(out_mean), e.mean);
`endif
        end
      end else begin
        chk("valid_low", int'(out_valid), 0);
        chk("hold_sum", int'(out_sum), hold_sum);
        chk("hold_full", int'(out_full), int'(hold_full));
`ifdef SLIDING_WINDOW_SUM_MEAN_EN
        chk("hold_mean", int'(out_mean), hold_mean);
`endif
      end
    end
  end

  initial begin
    errs     = 0;
    checks   = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_flush();
    #12;
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_full", int'(out_full), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0);

    // Back-to-back ramp
    for (int i = 1; i <= 6; i++) step(1, i, 0);
    step(0, 0, 0);

    // Same samples with two-cycle gaps
    step(0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, i, 0);
      step(0, 0, 0);
      step(0, 0, 0);
    end

    // Clear wins over a simultaneous sample
    step(1, 9, 1);
    step(0, 0, 0);
    chk("clear_sum", int'(out_sum), 0);
    chk("clear_full", int'(out_full), 0);
    step(1, 7, 0);
    step(0, 0, 0);
    chk("after_clear_sum", int'(out_sum), 7);

    // All-max samples: no wrap at full window
    for (int i = 0; i < 20; i++) step(1, 255, 0);
    step(0, 0, 0);
    chk("max_sum", int'(out_sum), 255 * W);
    chk("max_full", int'(out_full), 1);

    // Asynchronous reset between edges
    step(1, 5, 0);
    #2;
    sb.delete();
    rst = 1'b1;
    #1;
    chk("arst_sum", int'(out_sum), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_full", int'(out_full), 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(posedge clk);
    #1;
    chk("arst_hold_sum", int'(out_sum), 0);
    rst = 1'b0;
    model_flush();
    step(1, 2, 0);
    step(0, 0, 0);
    chk("post_rst_sum", int'(out_sum), 2);

    // Random traffic with occasional clears and max-value bursts
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit c;
      int d;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 49) == 0);
      d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      step(v, d, c);
    end

    repeat (3) step(0, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sliding_window_sum.md
Name: sliding_window_sum

Overview:
Streaming moving-window accumulator: out_sum is the sum of the last 2^LOG_W accepted input samples. It generalises the fixed past-sample adder with:
- a valid-qualified input, so bubbles do not advance the window;
- full-width output with no wrap;
- fill tracking, synchronous clear and asynchronous reset.

It sits in the datapath after sample capture and feeds averaging/threshold logic.

Parameters:
LOG_W, 3, log2 of window length W = 2^LOG_W samples; legal range 1..8.
DW, 8, input sample width, unsigned.
OW (localparam), DW+LOG_W, output sum width; guarantees no overflow.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous history flush
in_valid  input  1  in_data accepted on this edge when high
in_data  input  DW  unsigned sample
out_valid  output  1  one-cycle pulse: out_sum updated
out_sum  output  OW  sum of last W accepted samples
out_full  output  1  high once W samples accepted since reset/clear

Behaviour:
- Reset (rst=1, async): all history registers, partial sums, fill counter, out_sum, out_valid and out_full go to 0 immediately. State is held at 0 while rst is high.
- Accept: a sample is accepted on a rising edge with in_valid=1 and clear=0.
- Window contents: only accepted samples enter the window. Cycles with in_valid=0 leave the history, out_sum and out_full unchanged, and force out_valid=0.
- Output latency: 1 cycle. At the edge accepting sample x[n], the registers load out_sum = x[n]+x[n-1]+...+x[n-W+1] and set out_valid=1 for the following cycle.
- Empty slots: samples not yet received since reset/clear count as 0, so partial sums appear during fill.
- Structure: doubling tree of LOG_W stages.
  - Stage 1: s1 = x[n] + x[n-1].
  - Stage k: sk = s(k-1) + s(k-1) delayed by 2^(k-1) accepted samples.
  - Delay lines advance only on accept.
  - The combinational chain from in_data to the out_sum register is LOG_W adders deep.
  - Stage k arithmetic is DW+k bits wide. No truncation anywhere.
- Fill counter: LOG_W+1 bits.
  - Increments on each accept and saturates at W.
  - out_full=1 from the cycle after the W-th accept onward.
- Clear (clear=1 at an edge):
  - zeroes history, partial sums, counter and out_sum; out_full=0, out_valid=0;
  - has priority over a simultaneous in_valid, which is dropped.
- Steady state: after the window is full, each accept adds the newest sample and drops the oldest. Results stay exact for any sample mix, including all-max.
- No backpressure: the block accepts every in_valid cycle, including back-to-back samples at full rate.

Optional Feature:
Macro SLIDING_WINDOW_SUM_MEAN_EN.
- Defined: adds output port out_mean (DW bits) = (out_sum + 2^(LOG_W-1)) >> LOG_W.
  - Round-half-up; the result never exceeds 2^DW-1.
  - Registered on the same edge as out_sum.
  - Reset and clear value 0.
  - During fill the divisor is still W, so the value is not a partial average.
- Not defined: port out_mean is absent and there is no rounding logic. All other behaviour is identical.

Test Plan:
1. LOG_W=2, DW=8; accept 1,2,3,4,5,6 back-to-back -> out_sum 1,3,6,10,14,18, each with an out_valid pulse; out_full rises the cycle after the 4th accept.
2. Same inputs with 2-cycle in_valid gaps between samples -> identical out_sum sequence; out_valid=0 and out_sum held during gaps.
3. LOG_W=3, DW=8; accept 255 twenty times -> out_sum saturates at 2040 (OW=11, no wrap) and stays 2040.
4. After test 1, assert clear together with in_valid=1, in_data=9 -> sample dropped, out_sum=0, out_full=0. Then accept 7 -> out_sum=7.
5. Assert rst asynchronously mid-stream, between edges -> out_sum, out_valid, out_full go to 0 before the next edge. After release, accepting 2 gives out_sum=2.
6. With SLIDING_WINDOW_SUM_MEAN_EN, LOG_W=2; accept 1,2,3,4 then 5 -> out_mean 3 then 4 (10 gives (10+2)>>2=3; 14 gives 16>>2=4).
